// File: rtl/upload_packer.sv
// upload_packer: gathers one upload burst from an SPI handler into a local
// buffer, then streams it out as a framed packet:
//   HDR0, HDR1, source, len_hi, len_lo, payload..., checksum
// The checksum is the 8-bit sum of source, both length bytes and the payload.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for the first byte of a burst, in_ready high
// COLLECT  | storing bytes until burst end, buffer full or source change
// HDR0     | presenting first header byte
// HDR1     | presenting second header byte
// SRC      | presenting the latched source tag
// LENH     | presenting payload length, high byte
// LENL     | presenting payload length, low byte
// PAYLOAD  | presenting buffered payload bytes in order
// CSUM     | presenting checksum; on transfer, clear and return to IDLE
module upload_packer #(
  parameter int         MAX_PAYLOAD = 256,
  parameter logic [7:0] HDR0        = 8'hAA,
  parameter logic [7:0] HDR1        = 8'h44
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_active,
  input  logic [7:0] in_data,
  input  logic [7:0] in_source,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_COLLECT, ST_HDR0, ST_HDR1, ST_SRC,
    ST_LENH, ST_LENL, ST_PAYLOAD, ST_CSUM
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] rd_q;
  logic [7:0]    src_q;
  logic [7:0]    csum_q;
  logic [7:0]    mem [MAX_PAYLOAD];
  logic [15:0]   len;
  logic          acc;
  logic          xfer;
  logic          last_payload;

  assign len          = 16'(count_q);
  assign busy         = (state_q != ST_IDLE);
  assign xfer         = out_valid && out_ready;
  assign last_payload = (rd_q == count_q - CNT_ONE);

  // Next state, handshakes and the byte currently presented downstream.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    acc       = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          acc     = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // A byte from a different source is left pending for the next frame.
        if (count_q == MAX_CNT) begin
          state_d = ST_HDR0;
        end else if (in_valid && (in_source != src_q)) begin
          state_d = ST_HDR0;
        end else if (in_valid) begin
          in_ready = 1'b1;
          acc      = 1'b1;
        end else if (!in_active) begin
          state_d = ST_HDR0;
        end
      end
      ST_HDR0: begin
        out_valid = 1'b1;
        out_data  = HDR0;
        if (out_ready) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        out_valid = 1'b1;
        out_data  = HDR1;
        if (out_ready) state_d = ST_SRC;
      end
      ST_SRC: begin
        out_valid = 1'b1;
        out_data  = src_q;
        if (out_ready) state_d = ST_LENH;
      end
      ST_LENH: begin
        out_valid = 1'b1;
        out_data  = len[15:8];
        if (out_ready) state_d = ST_LENL;
      end
      ST_LENL: begin
        out_valid = 1'b1;
        out_data  = len[7:0];
        if (out_ready) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = mem[rd_q[AW-1:0]];
        if (out_ready && last_payload) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q + src_q + len[15:8] + len[7:0];
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus counters; payload sum accumulates as bytes are stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rd_q    <= '0;
      src_q   <= 8'h00;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      if (acc) begin
        count_q <= count_q + CNT_ONE;
        csum_q  <= csum_q + in_data;
        if (state_q == ST_IDLE) src_q <= in_source;
      end
      if ((state_q == ST_PAYLOAD) && xfer) rd_q <= rd_q + CNT_ONE;
      if ((state_q == ST_CSUM) && xfer) begin
        count_q <= '0;
        rd_q    <= '0;
        csum_q  <= 8'h00;
      end
    end
  end

  // Payload buffer write port; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (acc) mem[count_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_upload_packer.sv
// Bench for upload_packer: two instances (default depth and depth 4) share
// stimulus, selected by sel. Frames are compared against literal streams for
// directed cases and against a frame-building reference model for random bursts.
module tb_upload_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_active, in_valid, out_ready, sel;
  logic [7:0] in_data, in_source;
  logic       rdy_a, ov_a, busy_a, rdy_b, ov_b, busy_b;
  logic [7:0] od_a, od_b;
  logic       in_ready_s, ov_s, busy_s;
  logic [7:0] od_s;

  int n_chk  = 0;
  int n_pass = 0;
  int ro_mode  = 0;
  int ro_phase = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] bs_q[$];
  logic [7:0] bd_q[$];
  logic [7:0] pl_q[$];

  always #5 clk = ~clk;

  upload_packer dut_a (
    .clk(clk), .rst(rst),
    .in_active(in_active && !sel), .in_data(in_data), .in_source(in_source),
    .in_valid(in_valid && !sel), .in_ready(rdy_a),
    .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready && !sel),
    .busy(busy_a)
  );

  upload_packer #(.MAX_PAYLOAD(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_active(in_active && sel), .in_data(in_data), .in_source(in_source),
    .in_valid(in_valid && sel), .in_ready(rdy_b),
    .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready && sel),
    .busy(busy_b)
  );

  assign in_ready_s = sel ? rdy_b  : rdy_a;
  assign ov_s       = sel ? ov_b   : ov_a;
  assign od_s       = sel ? od_b   : od_a;
  assign busy_s     = sel ? busy_b : busy_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Downstream sink: drives out_ready, captures transfers, checks hold rules.
  initial begin
    forever begin
      @(negedge clk);
      case (ro_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((ro_phase % 4) == 0) || ((ro_phase % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      ro_phase++;
      #1;
      if (!rst) begin
        if (prev_stall) begin
          check("hold_valid", ov_s, 1);
          check("hold_data", od_s, prev_data);
        end
        if (ov_s) check("in_ready_low_emit", in_ready_s, 0);
        if (ov_s && out_ready) got_q.push_back(od_s);
        prev_stall = ov_s && !out_ready;
        prev_data  = od_s;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] s, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    in_active = 1'b1;
    in_valid  = 1'b1;
    in_source = s;
    in_data   = d;
    while (1) begin
      #2;
      if (in_ready_s) break;
      t++;
      if (t > 3000) begin
        check("in_ready_wait", in_ready_s, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic drive_burst(input bit gaps);
    for (int i = 0; i < bs_q.size(); i++) begin
      send(bs_q[i], bd_q[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    @(negedge clk);
    in_active = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic emit_frame(input logic [7:0] s);
    logic [7:0]  sum;
    logic [15:0] n;
    n   = 16'(pl_q.size());
    sum = s + n[15:8] + n[7:0];
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h44);
    exp_q.push_back(s);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
    foreach (pl_q[k]) begin
      exp_q.push_back(pl_q[k]);
      sum += pl_q[k];
    end
    exp_q.push_back(sum);
    pl_q.delete();
  endtask

  // Reference: split the byte list into frames on source change or full buffer.
  task automatic build_exp(input int maxp);
    logic [7:0] s = 8'h00;
    exp_q.delete();
    pl_q.delete();
    for (int i = 0; i < bs_q.size(); i++) begin
      if (pl_q.size() > 0 && (bs_q[i] != s || pl_q.size() == maxp)) emit_frame(s);
      if (pl_q.size() == 0) s = bs_q[i];
      pl_q.push_back(bd_q[i]);
    end
    if (pl_q.size() > 0) emit_frame(s);
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      #3;
      t++;
    end while (!((got_q.size() >= exp_q.size() && !busy_s) || t > 20000));
    check("drain_busy", busy_s, 0);
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
  endtask

  task automatic load(input logic [7:0] s, input logic [7:0] d[$]);
    bs_q.delete();
    bd_q.delete();
    foreach (d[i]) begin
      bs_q.push_back(s);
      bd_q.push_back(d[i]);
    end
  endtask

  task automatic rand_burst(input int maxlen);
    int n;
    logic [7:0] s;
    bs_q.delete();
    bd_q.delete();
    n = $urandom_range(1, maxlen);
    s = 8'($urandom_range(2, 3));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 5) == 0) s = s ^ 8'h01;
      bs_q.push_back(s);
      bd_q.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; sel = 1'b0; in_active = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; in_source = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    check("rst_in_ready", in_ready_s, 0);
    check("rst_out_valid", ov_s, 0);
    check("rst_out_data", od_s, 0);
    check("rst_busy", busy_s, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("idle_in_ready", in_ready_s, 1);

    // Test 1
    load(8'h03, '{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    exp_q = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h15};
    drive_burst(0);
    wait_done();
    compare("t1");
    #1;
    check("t1_idle_ready", in_ready_s, 1);

    // Test 2
    load(8'h02, '{8'h46, 8'h50, 8'h47, 8'h41, 8'h32, 8'h30, 8'h32, 8'h35});
    exp_q = '{8'hAA, 8'h44, 8'h02, 8'h00, 8'h08, 8'h46, 8'h50, 8'h47,
              8'h41, 8'h32, 8'h30, 8'h32, 8'h35, 8'hF1};
    drive_burst(1);
    wait_done();
    compare("t2");

    // Test 4: stalled sink, 1,0,0,1 pattern
    ro_mode = 1; ro_phase = 0;
    load(8'h03, '{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    exp_q = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h15};
    drive_burst(0);
    wait_done();
    compare("t4");
    ro_mode = 0;

    // Test 5: reset after three payload bytes of test 2
    load(8'h02, '{8'h46, 8'h50, 8'h47, 8'h41, 8'h32, 8'h30, 8'h32, 8'h35});
    drive_burst(0);
    t = 0;
    do begin
      @(negedge clk);
      #2;
      t++;
    end while (got_q.size() < 8 && t < 2000);
    check("t5_reached", got_q.size(), 8);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_valid", ov_s, 0);
    check("t5_rst_data", od_s, 0);
    check("t5_rst_ready", in_ready_s, 0);
    check("t5_rst_busy", busy_s, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #3;
    check("t5_no_csum", got_q.size(), 8);
    check("t5_idle", busy_s, 0);
    got_q.delete();
    load(8'h03, '{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    exp_q = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h15};
    drive_burst(0);
    wait_done();
    compare("t5_after");

    // Test 6: active without data, then a source change mid-burst
    @(negedge clk);
    in_active = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      check("t6_no_busy", busy_s, 0);
      check("t6_no_valid", ov_s, 0);
    end
    in_active = 1'b0;
    bs_q = '{8'h01, 8'h02};
    bd_q = '{8'hAA, 8'hBB};
    exp_q = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h01, 8'hAA, 8'hAC,
              8'hAA, 8'h44, 8'h02, 8'h00, 8'h01, 8'hBB, 8'hBE};
    drive_burst(0);
    wait_done();
    compare("t6");

    // Random bursts on the default-depth instance
    ro_mode = 2;
    for (int r = 0; r < 6; r++) begin
      rand_burst(24);
      build_exp(256);
      drive_burst(1);
      wait_done();
      compare($sformatf("rnd_a%0d", r));
    end

    // Test 3 on the depth-4 instance
    @(negedge clk);
    sel = 1'b1;
    ro_mode = 0;
    load(8'h01, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    exp_q = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAF,
              8'hAA, 8'h44, 8'h01, 8'h00, 8'h02, 8'h55, 8'h66, 8'hBE};
    drive_burst(0);
    wait_done();
    compare("t3");

    // Random bursts on the depth-4 instance
    ro_mode = 2;
    for (int r = 0; r < 6; r++) begin
      rand_burst(12);
      build_exp(4);
      drive_burst(1);
      wait_done();
      compare($sformatf("rnd_b%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/upload_packer.md
Name: upload_packer

Overview:
- Sits directly downstream of the SPI master/slave handlers' upload interface (upload_active, upload_data, upload_source, upload_valid, upload_ready).
- Collects one burst of upload bytes from a handler into an internal buffer.
- Emits the burst as a framed packet on a byte stream toward the USB TX path.
- Frame layout: HDR0, HDR1, source, len_hi, len_lo, payload, checksum.

Parameters:
- MAX_PAYLOAD, 256: buffer depth in bytes and the maximum payload per frame; legal range 1..65535.
- HDR0, 8'hAA: first frame header byte.
- HDR1, 8'h44: second frame header byte.

Ports:
- clk  input  1  system clock (60 MHz).
- rst  input  1  asynchronous, active-high reset.
- in_active  input  1  upload_active from the handler; high for the duration of a burst.
- in_data  input  8  upload_data byte.
- in_source  input  8  upload_source tag (for example 0x02 or 0x03).
- in_valid  input  1  upload_valid.
- in_ready  output  1  upload_ready back to the handler.
- out_data  output  8  framed byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the byte.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: clk and rst are the block's only clock and reset. rst is asynchronous and active-high. While in reset, in_ready=0, out_valid=0, out_data=0, busy=0, state=IDLE, count=0, checksum=0.
- States: IDLE, COLLECT, HDR0, HDR1, SRC, LENH, LENL, PAYLOAD, CSUM.
- IDLE:
  - in_ready=1.
  - A byte is accepted when in_valid && in_ready. The first accepted byte is written to buf[0], latches src=in_source, sets count=1 and moves to COLLECT.
  - in_active toggling with no accepted byte produces no frame.
- COLLECT:
  - in_ready = (count < MAX_PAYLOAD).
  - Each accepted byte: buf[count] <= in_data, count++.
- Packet close (COLLECT -> HDR0) occurs on the first cycle that any of these holds:
  - in_active=0 and in_valid=0.
  - count == MAX_PAYLOAD.
  - in_valid=1 and in_source != src. In this case in_ready is held 0 that cycle and the byte is not consumed; it starts the next packet after CSUM.
- Emit sequence:
  - Bytes in order: HDR0, HDR1, src, count[15:8], count[7:0], buf[0..count-1], checksum.
  - in_ready=0 throughout emission.
  - checksum = (src + len_hi + len_lo + sum of payload bytes) mod 256. Headers are excluded.
  - Running sum uses 8-bit wrap-around. It is accumulated as bytes are emitted or stored; either is allowed as long as the result matches.
- Output handshake (valid/ready):
  - out_valid rises no earlier than 1 cycle after close.
  - out_data and out_valid hold stable until out_ready=1.
  - A transfer occurs on out_valid && out_ready. The next byte may be presented the following cycle, so throughput is 1 byte/clk when out_ready stays high.
  - out_valid never drops without a transfer.
- After CSUM transfers: count=0, checksum=0, go to IDLE with in_ready=1 on the next cycle.
- Buffer read: a registered read is allowed, but no bubbles inside PAYLOAD when out_ready stays high (prefetch).
- Reset mid-collect or mid-emit: the frame is aborted immediately with no partial frame completion. All outputs return to their reset values.
- Simultaneous in_valid with a close condition on count==MAX_PAYLOAD: the byte is not accepted (in_ready=0) and is held for the next packet.
- Length field is 16 bits; count width is clog2(MAX_PAYLOAD+1).

Test Plan:
1. Source 0x03 sends AA BB CC DD with in_active high, then in_active falls; out_ready=1 -> stream AA 44 03 00 04 AA BB CC DD 15, busy low after the checksum.
2. Source 0x02 sends "FPGA2025" (46 50 47 41 32 30 32 35) -> AA 44 02 00 08 46 50 47 41 32 30 32 35 F1.
3. MAX_PAYLOAD=4, source 0x01 sends 11 22 33 44 55 66 in one active burst:
   - Frame AA 44 01 00 04 11 22 33 44 ((01+00+04+11+22+33+44) mod 256 = AF) first.
   - Then frame AA 44 01 00 02 55 66 (01+00+02+55+66) mod 256 = BE.
   - in_ready=0 while the first frame is being emitted.
4. Same stimulus as test 1 with out_ready toggling 1,0,0,1 repeatedly -> identical byte sequence, no byte dropped or duplicated, out_data stable while out_valid && !out_ready.
5. Assert rst for 3 cycles during PAYLOAD of test 2 (after 3 payload bytes) -> out_valid=0 immediately, no checksum byte emitted. A subsequent test 1 stimulus yields a clean frame ending in 15.
6. in_active pulses high for 10 cycles with in_valid=0 -> no out_valid, busy stays 0. Then source change mid-burst (01:AA then 02:BB) -> two frames AA 44 01 00 01 AA AC and AA 44 02 00 01 BB BE.
